cam_read: RTL
=============

# cam_read

Pixel capture stage between the OV7670 camera port and the 160x120 dual-port frame buffer in `test_cam`. It samples `CAM_vsync`, `CAM_href` and `CAM_px_data` on the pixel clock and assembles two RGB444 bytes into one 12-bit pixel. It writes each pixel to the buffer's write port at a linear address, so the VGA side can read a complete frame.

## Interface
- `IMG_W`, 160, pixels per line (bytes per line = 2*IMG_W)
- `IMG_H`, 120, lines per frame
- `AW`, 15, buffer address width; must satisfy 2^AW >= IMG_W*IMG_H

- `clk`  in  1  capture clock; top level connects `CAM_pclk` here; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `CAM_vsync`  in  1  frame sync; high = vertical blanking
- `CAM_href`  in  1  line valid; high = data bytes valid
- `CAM_px_data`  in  8  camera byte
- `DP_RAM_regW`  out  1  buffer write enable, one-cycle pulse per pixel
- `DP_RAM_addr_in`  out  AW  buffer write address
- `DP_RAM_data_in`  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- `frame_done`  out  1  one-cycle pulse at end of a captured frame
- `overflow`  out  1  sticky flag: pixels arrived beyond IMG_W*IMG_H in the current frame

## Operation
- Byte order is RGB444 mode: the first byte is xxxxRRRR, and R is taken from `px[3:0]`. The second byte is GGGGBBBB, with G from `px[7:4]` and B from `px[3:0]`.
- `vsync_q` is a register holding the previous-cycle `CAM_vsync`. A frame start is `vsync_q=1 && CAM_vsync=0`.
- FSM states:
  - WAIT_FRAME (reset state): waits for a frame start. On frame start: `pix_cnt<=0`, `overflow<=0`, go to BYTE_HI.
  - BYTE_HI: if `CAM_vsync=1`, go to WAIT_FRAME (see frame end). Else if `CAM_href=1`, latch `r_q<=px[3:0]` and go to BYTE_LO. Else stay.
  - BYTE_LO: if `CAM_vsync=1`, go to WAIT_FRAME. Else if `CAM_href=1`:
    - drive `DP_RAM_data_in<={r_q,px[7:4],px[3:0]}` and `DP_RAM_addr_in<=pix_cnt`;
    - if `pix_cnt<IMG_W*IMG_H`, set `DP_RAM_regW<=1` and `pix_cnt<=pix_cnt+1`; else set `regW<=0` and `overflow<=1`;
    - go to BYTE_HI.
  - BYTE_LO with `CAM_href=0`: the orphan first byte is discarded, no write, go to BYTE_HI.
- Frame end: `CAM_vsync=1` seen in BYTE_HI or BYTE_LO pulses `frame_done` for one cycle and returns to WAIT_FRAME. A pending half-pixel is dropped.
- `pix_cnt` is AW+1 bits wide and saturates at IMG_W*IMG_H. Addresses never exceed IMG_W*IMG_H-1.
- Line boundaries are implicit: the address is linear, and `href` low gaps only stall the FSM.

## Timing
- Reset values:
  - `DP_RAM_regW=0`, `DP_RAM_addr_in=0`, `DP_RAM_data_in=0`
  - `frame_done=0`, `overflow=0`
  - `vsync_q=1`, state WAIT_FRAME
- All outputs are registered.
- Write latency: the pixel is visible one cycle after the rising edge that samples its second byte.
- `DP_RAM_regW` is high for exactly one cycle and never high on two consecutive cycles.
- Addr and data are held stable until the next write. The buffer writes on the cycle `regW=1`.
- `frame_done` rises the cycle after vsync high is first sampled in a capture state.
- Frame start happens on the edge sampling vsync low. A byte with `href=1` on that same edge is ignored; the first usable byte is on the next edge.
- Reset mid-frame: immediate return to reset values. Capture resumes only at the next vsync falling edge, so no partial frame is written.

## Test plan
- Reset check: hold `rst=0` while toggling inputs. Required: all outputs 0, no `regW`. Release `rst`, then drive vsync 1->0 followed by bytes 0x0A, 0xBC with href=1. Required: one `regW` pulse, addr 0, data 0xABC.
- Full frame: 120 lines of 320 bytes (href=1) with 4-cycle href gaps, bytes 0xF0/0xF0. Required:
  - 19200 `regW` pulses, addresses 0..19199 in order, all data 0x0F0;
  - on vsync rise, `frame_done` for one cycle; `overflow=0`.
- Overflow: 121 lines in one frame. Required: writes stop after addr 19199, `overflow=1` from the first extra pixel, and `overflow` clears at the next frame start.
- Orphan byte: href=1 for 3 bytes (0x01, 0x23, 0x04), then href=0, then bytes 0x05, 0x67. Required: data 0x123 @0 and 0x567 @1; 0x04 is dropped.
- Vsync abort: vsync rises after 50 pixels. Required: `frame_done` pulse, no further writes, and the next frame restarts at addr 0.
- Reset mid-frame: assert `rst` at pixel 1000 and release while href is active. Required: no `regW` until the next vsync falling edge, then addr restarts at 0.

Source files
------------

// File: rtl/cam_read.sv
// cam_read: OV7670 RGB444 byte-pair capture into a linear 12-bit frame-buffer write port
module cam_read #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [11:0]   DP_RAM_data_in,
  output logic          frame_done,
  output logic          overflow
);
  localparam logic [AW:0] NPIX = (AW+1)'(IMG_W*IMG_H);
  typedef enum logic [1:0] {WAIT_FRAME, BYTE_HI, BYTE_LO} state_t;
  state_t      state;
  logic [AW:0] pix_cnt;
  logic [3:0]  r_q;
  logic        vsync_q;
  logic        vs_seen;
  // vs_seen blocks a frame start until vsync has been seen high after reset, so a reset mid-frame never resumes a partial frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= WAIT_FRAME;
      pix_cnt        <= '0;
      r_q            <= '0;
      vsync_q        <= 1'b1;
      vs_seen        <= 1'b0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      vsync_q     <= CAM_vsync;
      vs_seen     <= vs_seen | CAM_vsync;
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        WAIT_FRAME:
          if (vs_seen && vsync_q && !CAM_vsync) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
            state    <= BYTE_HI;
          end
        BYTE_HI:
          if (CAM_vsync) begin
            frame_done <= 1'b1;
            state      <= WAIT_FRAME;
          end else if (CAM_href) begin
            r_q   <= CAM_px_data[3:0];
            state <= BYTE_LO;
          end
        BYTE_LO:
          if (CAM_vsync) begin
            frame_done <= 1'b1;
            state      <= WAIT_FRAME;
          end else begin
            if (CAM_href) begin
              if (pix_cnt < NPIX) begin
                DP_RAM_data_in <= {r_q, CAM_px_data};
                DP_RAM_addr_in <= pix_cnt[AW-1:0];
                DP_RAM_regW    <= 1'b1;
                pix_cnt        <= pix_cnt + 1'b1;
              end else
                overflow <= 1'b1;
            end
            state <= BYTE_HI;
          end
        default: state <= WAIT_FRAME;
      endcase
    end
endmodule
